// File: rtl/maze_cell_picker.sv
// ---------------------------------------------------------------------------
// maze_cell_picker
//
// Turns the output of a free-running 11-bit LFSR into a uniformly distributed,
// in-bounds maze cell coordinate. The word is split into x = lfsr_in[10:5] and
// y = lfsr_in[4:0]. Words that fall outside the maze, or that hit the excluded
// cell, are thrown away rather than folded, so the result stays uniform.
// Samples are taken SKIP LFSR steps apart so that successive candidates are
// less correlated. After MAX_TRIES rejected samples a fixed fallback cell is
// returned, so every request completes in bounded time.
//
// Parameters:
//   MAZE_W    : maze width in cells, 2..64
//   MAZE_H    : maze height in cells, 1..32
//   SKIP      : LFSR steps between samples, >= 1
//   MAX_TRIES : rejected samples before fallback, >= 1
//
// Ports:
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high reset
//   lfsr_in    : current LFSR word (advances every clock)
//   start      : request a new cell, honoured only while busy = 0
//   excl_valid : exclusion cell active (captured with start)
//   excl_x     : excluded x coordinate (captured with start)
//   excl_y     : excluded y coordinate (captured with start)
//   busy       : a request is in progress
//   done       : one-cycle pulse; cell_x / cell_y / fallback are valid
//   cell_x     : chosen x, held until the next done
//   cell_y     : chosen y, held until the next done
//   fallback   : last result came from the fallback path
// ---------------------------------------------------------------------------
module maze_cell_picker #(
    parameter int MAZE_W    = 32,
    parameter int MAZE_H    = 24,
    parameter int SKIP      = 4,
    parameter int MAX_TRIES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] lfsr_in,
    input  logic        start,
    input  logic        excl_valid,
    input  logic [5:0]  excl_x,
    input  logic [4:0]  excl_y,
    output logic        busy,
    output logic        done,
    output logic [5:0]  cell_x,
    output logic [4:0]  cell_y,
    output logic        fallback
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // +1 keeps the counters at least one bit wide when SKIP or MAX_TRIES is 1
    localparam int SKIP_W  = $clog2(SKIP + 1);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    localparam logic [SKIP_W-1:0]  SKIP_LAST  = SKIP_W'(SKIP - 1);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);

    // Bounds are one bit wider than the fields so MAZE_W = 64 / MAZE_H = 32 fit
    localparam logic [6:0] W_LIMIT = 7'(MAZE_W);
    localparam logic [5:0] H_LIMIT = 6'(MAZE_H);

    logic [0:0]         state_reg,    state_next;
    logic [SKIP_W-1:0]  skip_reg,     skip_next;
    logic [TRIES_W-1:0] tries_reg,    tries_next;
    logic               excl_v_reg,   excl_v_next;
    logic [10:0]        excl_word_reg, excl_word_next;
    logic [5:0]         cell_x_reg,   cell_x_next;
    logic [4:0]         cell_y_reg,   cell_y_next;
    logic               fallback_reg, fallback_next;
    logic               done_reg,     done_next;

    // ---------------------------------------------------------------------
    // Candidate evaluation
    // ---------------------------------------------------------------------
    logic [5:0]  cand_x;
    logic [4:0]  cand_y;
    logic [10:0] match_bits;
    logic        in_range;
    logic        excl_hit;
    logic        accept;
    logic        excl_is_origin;

    assign cand_x = lfsr_in[10:5];
    assign cand_y = lfsr_in[4:0];

    // The exclusion is stored as a packed {x, y} word, the same layout as
    // the LFSR word, so the hit test is a plain bitwise equality.
    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_match
            assign match_bits[gi] = ~(lfsr_in[gi] ^ excl_word_reg[gi]);
        end
    endgenerate

    assign in_range = ({1'b0, cand_x} < W_LIMIT) && ({1'b0, cand_y} < H_LIMIT);
    assign excl_hit = excl_v_reg && (&match_bits);
    assign accept   = in_range && !excl_hit;

    // The fallback cell is (0,0) unless that cell is the one being avoided
    assign excl_is_origin = excl_v_reg && (excl_word_reg == 11'd0);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        skip_next      = skip_reg;
        tries_next     = tries_reg;
        excl_v_next    = excl_v_reg;
        excl_word_next = excl_word_reg;
        cell_x_next    = cell_x_reg;
        cell_y_next    = cell_y_reg;
        fallback_next  = fallback_reg;
        done_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    excl_v_next    = excl_valid;
                    excl_word_next = {excl_x, excl_y};
                    skip_next      = '0;
                    tries_next     = '0;
                    state_next     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (skip_reg == SKIP_LAST) begin
                    if (accept) begin
                        cell_x_next   = cand_x;
                        cell_y_next   = cand_y;
                        fallback_next = 1'b0;
                        done_next     = 1'b1;
                        state_next    = ST_IDLE;
                    end else if (tries_reg == TRIES_LAST) begin
                        cell_x_next   = excl_is_origin ? 6'd1 : 6'd0;
                        cell_y_next   = 5'd0;
                        fallback_next = 1'b1;
                        done_next     = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        tries_next = tries_reg + 1'b1;
                        skip_next  = '0;
                    end
                end else begin
                    skip_next = skip_reg + 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            skip_reg      <= '0;
            tries_reg     <= '0;
            excl_v_reg    <= 1'b0;
            excl_word_reg <= '0;
            cell_x_reg    <= '0;
            cell_y_reg    <= '0;
            fallback_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            skip_reg      <= skip_next;
            tries_reg     <= tries_next;
            excl_v_reg    <= excl_v_next;
            excl_word_reg <= excl_word_next;
            cell_x_reg    <= cell_x_next;
            cell_y_reg    <= cell_y_next;
            fallback_reg  <= fallback_next;
            done_reg      <= done_next;
        end
    end

    // The done cycle is already an IDLE cycle, so busy drops with done high
    assign busy     = (state_reg == ST_WAIT);
    assign done     = done_reg;
    assign cell_x   = cell_x_reg;
    assign cell_y   = cell_y_reg;
    assign fallback = fallback_reg;

endmodule
